// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS control types: FSM states, opcodes, ALUOp and mux encodings.
// CONTROLE_JUMP_EN adds the JUMP state and the jump-target PC source.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
`ifdef CONTROLE_JUMP_EN
    S_JUMP      = 4'd9,
`endif
    S_INVALID   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_J   = 6'd2;

  // ALUOp is also decoded by ALUControle; keep these values in step with it.
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
`ifdef CONTROLE_JUMP_EN
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
`endif

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       invalid_op;
  } ctrl_t;

endpackage

// File: rtl/controle_saidas.sv
// rtl/controle_saidas.sv - combinational state to control-vector decoder for the multicycle FSM.
// JUMP decode present only with CONTROLE_JUMP_EN.
module controle_saidas
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.memwrite   = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_REG;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.instr_done  = 1'b1;
      end
`ifdef CONTROLE_JUMP_EN
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_INVALID: ctrl.invalid_op = 1'b1;
      default: ctrl = '0;
    endcase

    // Reset lands the state in FETCH at once; suppress any architectural write meanwhile.
    if (reset) begin
      ctrl.pcwrite  = 1'b0;
      ctrl.irwrite  = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.regwrite = 1'b0;
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle MIPS main control FSM with memory-ready stalls.
// Define CONTROLE_JUMP_EN to execute opcode 2 as j; otherwise it decodes as invalid.
module controle_multiciclo
  import mips_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       invalid_op
);

  state_t state, state_next;
  ctrl_t  ctrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH: if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_R:         state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef CONTROLE_JUMP_EN
          OP_J:         state_next = S_JUMP;
`else
          OP_J:         state_next = S_INVALID;
`endif
          default:      state_next = S_INVALID;
        endcase
      end
      // IR holds the opcode, so the fallback to FETCH is only a safe exit.
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_next = S_MEM_READ;
        else if (opcode == OP_SW) state_next = S_MEM_WRITE;
        else                      state_next = S_FETCH;
      end
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_MEM_WB:    state_next = S_FETCH;
      S_R_EXEC:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
`ifdef CONTROLE_JUMP_EN
      S_JUMP:      state_next = S_FETCH;
`endif
      S_INVALID:   state_next = S_INVALID;
      default:     state_next = S_FETCH;
    endcase
  end

  controle_saidas u_saidas (
    .state     (state),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign IRWrite     = ctrl.irwrite;
  assign ALUSrcA     = ctrl.alusrca;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign PCSource    = ctrl.pcsource;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign instr_done  = ctrl.instr_done;
  assign invalid_op  = ctrl.invalid_op;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - table-driven check of controle_multiciclo, one vector per clock cycle.
// Honors CONTROLE_JUMP_EN for the opcode 2 expectation.
module tb_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, instr_done, invalid_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;

  controle_multiciclo dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .instr_done(instr_done), .invalid_op(invalid_op)
  );

  always #5 clock = ~clock;

  // Field order: pcw pcwc iord mr mw m2r irw srca rw rdst pcs[2] srcb[2] aop[2] done inv
  function automatic logic [17:0] mk(input logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rdst,
                                     input logic [1:0] pcs, srcb, aop, input logic done, inv);
    return {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rdst, pcs, srcb, aop, done, inv};
  endfunction

  localparam logic [17:0] F1   = mk(1,0,0,1,0,0,1,0,0,0, 2'd0, 2'd1, 2'd0, 0,0);
  localparam logic [17:0] F0   = mk(0,0,0,1,0,0,0,0,0,0, 2'd0, 2'd1, 2'd0, 0,0);
  localparam logic [17:0] DEC  = mk(0,0,0,0,0,0,0,0,0,0, 2'd0, 2'd3, 2'd0, 0,0);
  localparam logic [17:0] MA   = mk(0,0,0,0,0,0,0,1,0,0, 2'd0, 2'd2, 2'd0, 0,0);
  localparam logic [17:0] MR   = mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0,0);
  localparam logic [17:0] MWB  = mk(0,0,0,0,0,1,0,0,1,0, 2'd0, 2'd0, 2'd0, 1,0);
  localparam logic [17:0] MW1  = mk(0,0,1,0,1,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 1,0);
  localparam logic [17:0] MW0  = mk(0,0,1,0,1,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0,0);
  localparam logic [17:0] REX  = mk(0,0,0,0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd2, 0,0);
  localparam logic [17:0] RWB  = mk(0,0,0,0,0,0,0,0,1,1, 2'd0, 2'd0, 2'd0, 1,0);
  localparam logic [17:0] BR   = mk(0,1,0,0,0,0,0,1,0,0, 2'd1, 2'd0, 2'd1, 1,0);
  localparam logic [17:0] INV  = mk(0,0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0,1);
`ifdef CONTROLE_JUMP_EN
  localparam logic [17:0] OP2E = mk(1,0,0,0,0,0,0,0,0,0, 2'd2, 2'd0, 2'd0, 1,0);
`else
  localparam logic [17:0] OP2E = INV;
`endif

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [17:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [17:0] outs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
            RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, instr_done, invalid_op};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic [17:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] exp);
    logic [17:0] got;
    got = outs();
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b want %b", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1;

    add(1, 0, 1, F0,  "reset_state");
    add(0, 0, 1, F1,  "r_fetch");
    add(0, 0, 1, DEC, "r_decode");
    add(0, 0, 1, REX, "r_exec");
    add(0, 0, 1, RWB, "r_wb_done_c4");
    add(0, 35, 1, F1,  "lw_fetch");
    add(0, 35, 1, DEC, "lw_decode");
    add(0, 35, 1, MA,  "lw_addr");
    add(0, 35, 0, MR,  "lw_read_wait1");
    add(0, 35, 0, MR,  "lw_read_wait2");
    add(0, 35, 0, MR,  "lw_read_wait3");
    add(0, 35, 1, MR,  "lw_read_ready");
    add(0, 35, 1, MWB, "lw_wb_done_c8");
    add(0, 43, 1, F1,  "sw_fetch");
    add(0, 43, 1, DEC, "sw_decode");
    add(0, 43, 1, MA,  "sw_addr");
    add(0, 43, 1, MW1, "sw_write_done_c4");
    add(0, 43, 0, F0,  "sw2_fetch_wait");
    add(0, 43, 1, F1,  "sw2_fetch");
    add(0, 43, 1, DEC, "sw2_decode");
    add(0, 43, 1, MA,  "sw2_addr");
    add(0, 43, 0, MW0, "sw2_write_wait");
    add(0, 43, 1, MW1, "sw2_write_done");
    add(0, 4, 1, F1,  "beq_fetch");
    add(0, 4, 1, DEC, "beq_decode");
    add(0, 4, 1, BR,  "beq_branch_c3");
    add(0, 63, 1, F1,  "opig_fetch");
    add(0, 0, 1, DEC,  "opig_decode");
    add(0, 63, 1, REX, "opig_exec");
    add(0, 63, 0, RWB, "opig_wb");
    add(0, 2, 1, F1,   "op2_fetch");
    add(0, 2, 1, DEC,  "op2_decode");
    add(0, 2, 1, OP2E, "op2_result");
    add(1, 2, 1, F0,   "op2_reset");

    next_cycle();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      #3;
      check(vecs[i].name, vecs[i].exp);
      next_cycle();
    end

    // Reset asserted in the middle of MEM_WB must kill the register write immediately.
    reset = 1'b0; opcode = 6'd35; mem_ready = 1'b1;
    #3; check("mwb_seq_fetch", F1);
    next_cycle(); #3; check("mwb_seq_decode", DEC);
    next_cycle(); #3; check("mwb_seq_addr", MA);
    next_cycle(); #3; check("mwb_seq_read", MR);
    next_cycle(); #3; check("mwb_seq_wb", MWB);
    reset = 1'b1;
    #1; check("mwb_reset_async", F0);
    next_cycle();
    reset = 1'b0;
    #3; check("mwb_after_reset_fetch", F1);

    // Unsupported opcode: sticky invalid, no enables whatever the inputs do.
    opcode = 6'd63;
    next_cycle(); #3; check("inv_decode", DEC);
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      opcode = 6'($urandom_range(0, 63));
      mem_ready = 1'($urandom_range(0, 1));
      #3;
      check($sformatf("inv_hold_%0d", k), INV);
    end
    reset = 1'b1; mem_ready = 1'b1;
    #1; check("inv_cleared_by_reset", F0);
    next_cycle();
    reset = 1'b0; opcode = 6'd4;
    #3; check("inv_post_fetch", F1);
    next_cycle(); #3; check("inv_post_decode", DEC);
    next_cycle(); #3; check("inv_post_branch", BR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle main control FSM for the MIPS datapath. Decodes the 6-bit instruction opcode and sequences fetch, decode, execute, memory and writeback over several cycles. Drives every datapath mux select and write enable, including the 2-bit `ALUOp` consumed by `ALUControle`. Stalls on a memory-ready handshake.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `opcode`  in  6  instruction bits [31:26], valid from DECODE onward (held by IR)
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  standard multicycle control lines
- `PCSource`  out  2  PC mux select: 0 = ALU, 1 = ALUOut, 2 = jump target
- `ALUSrcB`  out  2  ALU B mux select: 0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- `ALUOp`  out  2  0 = add, 1 = sub, 2 = use funct (to `ALUControle`)
- `instr_done`  out  1  one-cycle pulse on the last cycle of each instruction
- `invalid_op`  out  1  sticky; unsupported opcode decoded

## Operation
- Opcodes: R = 0, lw = 35, sw = 43, beq = 4, j = 2.
- States and transitions:
  - FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALUOp = 0, PCSource = 0. IRWrite and PCWrite equal `mem_ready`. Stay while `mem_ready` = 0; go to DECODE when 1.
  - DECODE: ALUSrcA = 0, ALUSrcB = 3, ALUOp = 0 (branch target into ALUOut). Next state by opcode: lw/sw → MEM_ADDR, R → R_EXEC, beq → BRANCH, j → JUMP, anything else → INVALID.
  - MEM_ADDR: ALUSrcA = 1, ALUSrcB = 2, ALUOp = 0. lw → MEM_READ, sw → MEM_WRITE.
  - MEM_READ: MemRead = 1, IorD = 1. Hold until `mem_ready`, then go to MEM_WB.
  - MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. `instr_done` = 1. Go to FETCH.
  - MEM_WRITE: MemWrite = 1, IorD = 1. Hold while `mem_ready` = 0. When `mem_ready` = 1: `instr_done` = 1, go to FETCH.
  - R_EXEC: ALUSrcA = 1, ALUSrcB = 0, ALUOp = 2. Go to R_WB.
  - R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. `instr_done` = 1. Go to FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 0, ALUOp = 1, PCWriteCond = 1, PCSource = 1. `instr_done` = 1. Go to FETCH.
  - JUMP: PCWrite = 1, PCSource = 2. `instr_done` = 1. Go to FETCH.
  - INVALID: all enables 0. `invalid_op` = 1. Terminal; exits only on `reset`.
- Every signal not listed for a state is 0.
- Outputs are Moore (decoded from the state register), except the FETCH/MEM_WRITE qualification by `mem_ready`.
- `reset` forces state to FETCH and clears `invalid_op`. While `reset` = 1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Reset mid-instruction aborts the instruction. No partial writeback occurs after reset is asserted.

## Timing
- Reset value of every output is 0, except the FETCH select/read lines: MemRead = 1 and ALUSrcB = 1.
- Zero-wait-state latency (FETCH through done): R = 4 cycles, lw = 5, sw = 4, beq = 3, j = 3.
- Each cycle of `mem_ready` = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `opcode` is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- `invalid_op` is set on the clock edge leaving DECODE.

## Configuration
- `CONTROLE_JUMP_EN` defined: JUMP state present; opcode 2 executes as j.
- `CONTROLE_JUMP_EN` undefined: JUMP state removed; opcode 2 goes to INVALID; PCSource never equals 2.

## Structure
- Shared package `mips_pkg`:
  - state enum
  - opcode constants
  - ALUOp constants (ADD = 0, SUB = 1, FUNCT = 2), shared with `ALUControle`
  - PCSource and ALUSrcB encodings
- One natural sub-module: `controle_saidas`, a combinational state → control-vector decoder. The FSM proper keeps only the state register and next-state logic.

## Test plan
- Reset asserted mid-MEM_WB → RegWrite drops to 0 immediately; state = FETCH; `invalid_op` = 0.
- R-type (opcode 0), `mem_ready` = 1 constantly → `instr_done` on cycle 4; ALUOp = 2 in R_EXEC; RegDst = 1 and RegWrite = 1 in R_WB.
- lw (opcode 35) with `mem_ready` low 3 cycles in MEM_READ → `instr_done` on cycle 8; IorD = 1 throughout MEM_READ.
- sw (opcode 43) → MemWrite = 1 for exactly one cycle; RegWrite never asserted; done at cycle 4.
- beq (opcode 4) → PCWriteCond = 1, ALUOp = 1, PCSource = 1 on cycle 3; then FETCH.
- Opcode 63 (and opcode 2 without `CONTROLE_JUMP_EN`) → `invalid_op` = 1 and stays; no enables for 20 cycles; cleared by reset.
